// File: rtl/ct_f_spsram_pkg.sv
// rtl/ct_f_spsram_pkg.sv - shared types and sizing helpers for the banked single-port SRAM wrapper
package ct_f_spsram_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } fsm_state_t;

  function automatic int seg_num(input int data_width, input int wrap_size);
    return data_width / wrap_size;
  endfunction

  function automatic int bank_bits(input int bank_num);
    return (bank_num <= 1) ? 0 : $clog2(bank_num);
  endfunction

endpackage

// File: rtl/ct_f_spsram_bank.sv
// rtl/ct_f_spsram_bank.sv - one bank: SEG_NUM RAM columns sharing a row address, per-segment write enable
module ct_f_spsram_bank #(
  parameter int ROW_WIDTH  = 12,
  parameter int DATA_WIDTH = 128,
  parameter int WRAP_SIZE  = 32,
  parameter int SEG_NUM    = 4
) (
  input  logic                  clk,
  input  logic [SEG_NUM-1:0]    we,
  input  logic [ROW_WIDTH-1:0]  addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  for (genvar s = 0; s < SEG_NUM; s++) begin : g_seg
    fpga_ram #(
      .DATAWIDTH(WRAP_SIZE),
      .ADDRWIDTH(ROW_WIDTH)
    ) u_ram (
      .clk (clk),
      .we  (we[s]),
      .addr(addr),
      .din (din[s*WRAP_SIZE +: WRAP_SIZE]),
      .dout(dout[s*WRAP_SIZE +: WRAP_SIZE])
    );
  end

endmodule

// File: rtl/fpga_ram.sv
// rtl/fpga_ram.sv - behavioural single-port block RAM column with registered read (read-first)
module fpga_ram #(
  parameter int DATAWIDTH = 32,
  parameter int ADDRWIDTH = 12
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDRWIDTH-1:0] addr,
  input  logic [DATAWIDTH-1:0] din,
  output logic [DATAWIDTH-1:0] dout
);

  logic [DATAWIDTH-1:0] mem [2**ADDRWIDTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= din;
    end
    dout <= mem[addr];
  end

endmodule

// File: rtl/ct_f_spsram_banked.sv
// rtl/ct_f_spsram_banked.sv - banked single-port SRAM wrapper with zeroing sweep and Q hold
// Optional CT_F_SPSRAM_OUTREG_EN adds an output register stage (read latency 2).
module ct_f_spsram_banked
  import ct_f_spsram_pkg::*;
#(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 128,
  parameter int WRAP_SIZE  = 32,
  parameter int BANK_NUM   = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [ADDR_WIDTH-1:0] A,
  input  logic                  CEN,
  input  logic                  GWEN,
  input  logic [DATA_WIDTH-1:0] WEN,
  input  logic [DATA_WIDTH-1:0] D,
  output logic [DATA_WIDTH-1:0] Q,
  output logic                  INIT_BUSY
);

  localparam int SEG_NUM   = seg_num(DATA_WIDTH, WRAP_SIZE);
  localparam int BANK_BITS = bank_bits(BANK_NUM);
  localparam int ROW_WIDTH = ADDR_WIDTH - BANK_BITS;
  localparam int SEL_W     = (BANK_BITS > 0) ? BANK_BITS : 1;
  localparam logic [ROW_WIDTH-1:0] LAST_ROW = '1;

  if (DATA_WIDTH % WRAP_SIZE != 0) begin : g_bad_width
    $error("ct_f_spsram_banked: DATA_WIDTH must be a multiple of WRAP_SIZE");
  end
  if (BANK_NUM < 1 || (BANK_NUM & (BANK_NUM - 1)) != 0) begin : g_bad_banks
    $error("ct_f_spsram_banked: BANK_NUM must be a power of 2");
  end

  fsm_state_t            state;
  logic [ROW_WIDTH-1:0]  init_row;
  logic [ROW_WIDTH-1:0]  addr_holding;
  logic [SEL_W-1:0]      bank_sel;
  logic                  rd_pend;
  logic [DATA_WIDTH-1:0] q_stage;

  logic                  access;
  logic                  wr_access;
  logic                  rd_access;
  logic [SEL_W-1:0]      a_bank;
  logic [SEG_NUM-1:0]    seg_wen;
  logic [ROW_WIDTH-1:0]  ram_addr;
  logic [DATA_WIDTH-1:0] ram_din;
  logic [DATA_WIDTH-1:0] bank_q [BANK_NUM];
  logic                  wen_unused;

  // Only the MSB of each segment is a real enable; the other bits are don't-care.
  assign wen_unused = ^WEN;

  if (BANK_BITS > 0) begin : g_bank_dec
    assign a_bank = A[ADDR_WIDTH-1 -: SEL_W];
  end else begin : g_no_bank_dec
    assign a_bank = '0;
  end

  assign access    = !CEN && !INIT_BUSY;
  assign wr_access = access && !GWEN;
  assign rd_access = access && GWEN;

  always_comb begin
    seg_wen = '0;
    for (int s = 0; s < SEG_NUM; s++) begin
      seg_wen[s] = ~WEN[s*WRAP_SIZE + WRAP_SIZE - 1];
    end
  end

  // Idle cycles replay the held row so the RAM outputs stay put.
  always_comb begin
    ram_addr = addr_holding;
    ram_din  = D;
    if (state == INIT) begin
      ram_addr = init_row;
      ram_din  = '0;
    end else if (access) begin
      ram_addr = A[ROW_WIDTH-1:0];
    end
  end

  for (genvar b = 0; b < BANK_NUM; b++) begin : g_bank
    logic [SEG_NUM-1:0] bank_we;

    always_comb begin
      bank_we = '0;
      if (state == INIT) begin
        bank_we = '1;
      end else if (wr_access && a_bank == SEL_W'(b)) begin
        bank_we = seg_wen;
      end
    end

    ct_f_spsram_bank #(
      .ROW_WIDTH (ROW_WIDTH),
      .DATA_WIDTH(DATA_WIDTH),
      .WRAP_SIZE (WRAP_SIZE),
      .SEG_NUM   (SEG_NUM)
    ) u_bank (
      .clk (CLK),
      .we  (bank_we),
      .addr(ram_addr),
      .din (ram_din),
      .dout(bank_q[b])
    );
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= INIT;
      init_row     <= '0;
      INIT_BUSY    <= 1'b1;
      addr_holding <= '0;
      bank_sel     <= '0;
      rd_pend      <= 1'b0;
      q_stage      <= '0;
    end else begin
      case (state)
        INIT: begin
          init_row <= init_row + 1'b1;
          if (init_row == LAST_ROW) begin
            state     <= RUN;
            INIT_BUSY <= 1'b0;
          end
        end
        RUN: begin
          INIT_BUSY <= 1'b0;
        end
        default: begin
          state <= INIT;
        end
      endcase
      if (access) begin
        addr_holding <= A[ROW_WIDTH-1:0];
      end
      if (rd_access) begin
        bank_sel <= a_bank;
      end
      // Q only moves one cycle after a read; writes and idles leave it alone.
      rd_pend <= rd_access;
      if (rd_pend) begin
        q_stage <= bank_q[bank_sel];
      end
    end
  end

`ifdef CT_F_SPSRAM_OUTREG_EN
  logic                  rd_pend2;
  logic [DATA_WIDTH-1:0] q_out;

  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_pend2 <= 1'b0;
      q_out    <= '0;
    end else begin
      rd_pend2 <= rd_pend;
      if (rd_pend2) begin
        q_out <= q_stage;
      end
    end
  end

  assign Q = q_out;
`else
  assign Q = q_stage;
`endif

endmodule

// File: tb/tb_ct_f_spsram_banked.sv
// tb/tb_ct_f_spsram_banked.sv - scoreboard bench with a word-level memory model for ct_f_spsram_banked
module tb_ct_f_spsram_banked;
  localparam int AW = 13;
  localparam int DW = 128;
  localparam int WS = 32;
  localparam int SN = DW / WS;
  localparam int INIT_CYCLES = 4096;
`ifdef CT_F_SPSRAM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] a = '0;
  logic          cen = 1'b1;
  logic          gwen = 1'b1;
  logic [DW-1:0] wen = '1;
  logic [DW-1:0] d = '0;
  logic [DW-1:0] q;
  logic          init_busy;

  always #5 clk = ~clk;

  ct_f_spsram_banked dut (
    .CLK      (clk),
    .RST      (rst),
    .A        (a),
    .CEN      (cen),
    .GWEN     (gwen),
    .WEN      (wen),
    .D        (d),
    .Q        (q),
    .INIT_BUSY(init_busy)
  );

  typedef struct {
    int            due;
    logic [DW-1:0] exp;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] model[int];
  logic [DW-1:0] cur_q = '0;
  int            cyc = 0;
  bit            mon_en = 1'b0;
  int            checks = 0;
  int            errors = 0;

  always @(posedge clk) cyc++;

  // Expected Q is the most recently completed read; it must hold every other cycle.
  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].due < cyc) begin
      checks++;
      errors++;
      $display("FAIL sb_stale cyc=%0d due=%0d", cyc, sb[0].due);
      void'(sb.pop_front());
    end
    if (sb.size() > 0 && sb[0].due == cyc) begin
      cur_q = sb[0].exp;
      void'(sb.pop_front());
    end
    if (mon_en) begin
      checks++;
      if (q !== cur_q) begin
        errors++;
        $display("FAIL q cyc=%0d got=%h exp=%h", cyc, q, cur_q);
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] mget(input logic [AW-1:0] addr);
    if (model.exists(int'(addr))) return model[int'(addr)];
    return '0;
  endfunction

  task automatic wr(input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic [DW-1:0] mask);
    logic [DW-1:0] w;
    w = mget(addr);
    for (int s = 0; s < SN; s++) begin
      if (!mask[s*WS + WS - 1]) w[s*WS +: WS] = data[s*WS +: WS];
    end
    model[int'(addr)] = w;
    a = addr; d = data; wen = mask; cen = 1'b0; gwen = 1'b0;
    @(negedge clk);
    cen = 1'b1; gwen = 1'b1;
  endtask

  task automatic rd(input logic [AW-1:0] addr);
    exp_t e;
    e.due = cyc + 1 + LAT;
    e.exp = mget(addr);
    sb.push_back(e);
    a = addr; d = {4{$urandom}}; wen = {4{$urandom}}; cen = 1'b0; gwen = 1'b1;
    @(negedge clk);
    cen = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      a = AW'($urandom); d = {4{$urandom}}; wen = {4{$urandom}};
      gwen = 1'($urandom); cen = 1'b1;
      @(negedge clk);
    end
  endtask

  // Holds RST for 'hold' cycles, then counts INIT_BUSY cycles (or bails out at abort_at).
  task automatic do_reset(input int hold, input int abort_at, input bit poke);
    int n;
    mon_en = 1'b0;
    rst = 1'b1; cen = 1'b1; gwen = 1'b1;
    repeat (hold) @(negedge clk);
    rst = 1'b0;
    sb.delete();
    cur_q = '0;
    model.delete();
    mon_en = 1'b1;
    n = 0;
    while (init_busy === 1'b1 && n < 10000) begin
      if (abort_at != 0 && n == abort_at) return;
      if (poke && n == 200) begin
        a = AW'('h10); d = '1; wen = '0; cen = 1'b0; gwen = 1'b0;
      end else if (poke && n == 300) begin
        a = AW'('h10); cen = 1'b0; gwen = 1'b1;
      end else begin
        cen = 1'b1; gwen = 1'b1;
      end
      n++;
      @(negedge clk);
    end
    cen = 1'b1; gwen = 1'b1;
    chk("init_busy_cycles", 64'(n), 64'(INIT_CYCLES));
  endtask

  logic [AW-1:0] pool[8];

  initial begin
    #5_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    pool[0] = 'h0000; pool[1] = 'h0005; pool[2] = 'h1005; pool[3] = 'h1234;
    pool[4] = 'h0FFF; pool[5] = 'h1000; pool[6] = 'h1FFF; pool[7] = 'h0010;

    do_reset(2, 0, 1'b1);
    chk("busy_low_after_init", 64'(init_busy), 64'd0);

    rd('h0000); rd('h0FFF); rd('h1000); rd('h1FFF); rd('h0010);
    idle(3);

    wr('h1234, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210,
       128'hFFFF_FFFF_7FFF_FFFF_FFFF_FFFF_7FFF_FFFF);
    rd('h1234);
    idle(2);

    wr('h0005, {4{32'hAAAA_AAAA}}, '0);
    wr('h1005, {4{32'h5555_5555}}, '0);
    rd('h0005);
    idle(3);
    wr('h0005, {4{32'h1111_1111}}, '0);
    idle(2);
    rd('h0005);
    rd('h1005);
    idle(3);

    wr('h1FFF, {4{32'hDEAD_BEEF}}, '0);
    wr('h0000, {4{32'hCAFE_0000}}, '0);
    wr('h0001, {4{32'hCAFE_0001}}, '0);
    rd('h1FFF);
    idle(3);
    rd('h0000);
    rd('h0001);
    idle(3);

    for (int i = 0; i < 400; i++) begin
      logic [AW-1:0] ad;
      int op;
      ad = ($urandom_range(0, 3) == 0) ? AW'($urandom) : pool[$urandom_range(0, 7)];
      op = $urandom_range(0, 2);
      if (op == 0) wr(ad, {4{$urandom}}, {4{$urandom}});
      else if (op == 1) rd(ad);
      else idle(1);
    end
    idle(LAT + 3);

    do_reset(2, 1000, 1'b0);
    do_reset(1, 0, 1'b0);
    rd('h1234); rd('h0005); rd('h1FFF);
    idle(LAT + 3);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ct_f_spsram_banked.md
Name: ct_f_spsram_banked

Overview:
- Parametrised FPGA single-port SRAM wrapper, successor to the fixed 8192x128 wrappers; drop-in for L2 data/tag and IFU/LSU array shells on the FPGA target.
- Adds configurable depth, width and write-mask granularity, banking by address MSBs, a post-reset zero-initialisation sweep, and Q hold semantics.
- Each segment of each bank is one fpga_ram instance.

Parameters:
- ADDR_WIDTH, 13, word address width; depth = 2^ADDR_WIDTH.
- DATA_WIDTH, 128, data width; must be a multiple of WRAP_SIZE.
- WRAP_SIZE, 32, write-mask granularity; one fpga_ram column per segment; SEG_NUM = DATA_WIDTH/WRAP_SIZE.
- BANK_NUM, 2, power of 2, at most 2^ADDR_WIDTH.
- Derived: BANK_BITS = log2(BANK_NUM); ROW_WIDTH = ADDR_WIDTH-BANK_BITS.

Ports:
- CLK  in  1  clock.
- RST  in  1  reset.
- A  in  ADDR_WIDTH  word address.
- CEN  in  1  chip enable, active-low.
- GWEN  in  1  global write enable, active-low.
- WEN  in  DATA_WIDTH  bit write enables, active-low; only the MSB of each WRAP_SIZE segment is sampled.
- D  in  DATA_WIDTH  write data.
- Q  out  DATA_WIDTH  read data.
- INIT_BUSY  out  1  high while the zeroing sweep runs.

Interface: one clock, CLK; reset RST is synchronous and active-high.

Behaviour:
- Address decode: A[ADDR_WIDTH-1 -: BANK_BITS] selects the bank; A[ROW_WIDTH-1:0] selects the row. With BANK_NUM=1 there are no bank bits.
- Access gating: a cycle is an access when CEN=0 and INIT_BUSY=0.
  - Write when GWEN=0.
  - Read when GWEN=1.
- Write: segment s of the selected bank is written iff the cycle is a write and WEN[s*WRAP_SIZE+WRAP_SIZE-1]=0. Data is D[s*WRAP_SIZE +: WRAP_SIZE]. Unselected banks see no write enable.
- Address hold: an addr_holding register captures A on every access cycle. On non-access cycles the RAMs are driven with addr_holding, so fpga_ram output stays stable.
- Read latency: 1 cycle; Q is valid on the edge after the read-access edge.
  - A bank_sel register, captured on read accesses only, steers the Q mux.
  - Q holds the last read data through idle cycles and write cycles. Writes never change Q, even to the address last read, until the next read.
  - A Q-valid/hold register implements this; there is no combinational dependence of Q on CEN.
- Init FSM, states INIT and RUN:
  - RST=1 (sampled at the edge): state<=INIT, row counter<=0, Q<=0, addr_holding<=0, bank_sel<=0, INIT_BUSY<=1.
  - INIT: every bank and every segment writes zero at row counter; counter increments each cycle. When counter == 2^ROW_WIDTH-1, the write completes and state<=RUN. Total duration: 2^ROW_WIDTH cycles.
  - RUN: INIT_BUSY=0; stays in RUN until RST.
  - RST asserted mid-INIT or in RUN restarts the sweep from row 0.
  - CEN/GWEN/WEN/D/A are ignored during INIT; no queuing, and the requester must wait on INIT_BUSY.
- Boundaries:
  - Row counter is ROW_WIDTH bits; its terminal compare is exact, with no wrap back to 0 in RUN.
  - Highest address 2^ADDR_WIDTH-1 maps to the last bank, last row.
  - Illegal parameters (DATA_WIDTH%WRAP_SIZE!=0, BANK_NUM not a power of 2) fail elaboration via a generate-time $error.

Optional Feature:
- Macro CT_F_SPSRAM_OUTREG_EN.
  - Defined: an additional output register stage is added after the bank mux. Read latency becomes 2 cycles. The hold rule applies at the new stage, and the register resets to 0.
  - Undefined: 1-cycle latency as above.
- INIT duration and write behaviour are unaffected.

Decomposition:
- Package ct_f_spsram_pkg holds:
  - typedef fsm_state_t {INIT, RUN};
  - functions seg_num(DATA_WIDTH, WRAP_SIZE) and bank_bits(BANK_NUM).
- Sub-module ct_f_spsram_bank: one bank. It holds SEG_NUM fpga_ram instances (DATAWIDTH=WRAP_SIZE, ADDRWIDTH=ROW_WIDTH), with per-segment write enable and a shared row address.
- Top level holds the FSM, address hold, bank select and the Q register.

Test Plan:
- Reset, defaults: RST high 2 cycles then low -> INIT_BUSY=1 for exactly 4096 cycles, then 0. Q=0 throughout. Reading 0x0000, 0x0FFF, 0x1000 and 0x1FFF afterwards returns 0.
- Write during INIT: GWEN=0, CEN=0, A=0x10, D=all ones while INIT_BUSY=1 -> after INIT, reading 0x10 returns 0.
- Partial write: write A=0x1234, D=0x0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, with WEN MSBs 0 for segments 0 and 2 only -> read returns 0x0000_0000_89AB_CDEF_0000_0000_7654_3210.
- Bank isolation and hold: write 0xAA.. to 0x0005 and 0x55.. to 0x1005, then read 0x0005 -> Q=0xAA.. one cycle later. Q is unchanged through 3 idle cycles and through a write to 0x0005 of 0x11.. until the next read returns 0x11...
- Reset mid-init: RST pulsed at cycle 1000 of INIT -> INIT_BUSY stays high a further 4096 cycles from RST deassert.
- Build with CT_F_SPSRAM_OUTREG_EN: read of 0x1FFF after writing 0xDEAD_BEEF.. -> data appears 2 cycles after the read edge and holds; back-to-back reads of 0x0, then 0x1 stream one result per cycle.
